// File: rtl/exec_alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle arithmetic/logic with x86 flags,
// plus bit-serial shifts and rotates that move one bit per clock.
module exec_alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [4:0]       iFunc,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [4:0]       iCount,
    input  logic [5:0]       iFlags,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult,
    output logic [5:0]       oFlags
);
    localparam int M = WIDTH - 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] work, work_n, result_n;
    logic             carry, carry_n;
    logic [4:0]       remaining, remaining_n;
    logic [2:0]       sh_op, sh_op_n;
    logic [5:0]       sh_flags, sh_flags_n, flags_n;
    logic             orig_msb, orig_msb_n, done_n;

    // Flag vector layout {OF,SF,ZF,AF,PF,CF}; PF is even parity of the low byte.
    function automatic logic [5:0] mk_flags(input logic of, input logic [WIDTH-1:0] r,
                                            input logic af, input logic cf);
        return {of, r[M], (r == '0), af, ~^r[7:0], cf};
    endfunction

    // Single-cycle datapath: one shared adder/subtractor covers ADD..CMP and INC/DEC/NEG.
    logic [WIDTH-1:0] x, y, ar, alu_res;
    logic [WIDTH:0]   arith;
    logic             cin, sub, ovf, aux;
    logic [5:0]       alu_flags;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        x   = iA;
        y   = iB;
        cin = 1'b0;
        sub = 1'b0;
        case (iFunc)
            5'd2:        cin = iFlags[0];
            5'd3:        begin sub = 1'b1; cin = iFlags[0]; end
            5'd5, 5'd7:  sub = 1'b1;
            5'd16:       y = WIDTH'(1);
            5'd17:       begin y = WIDTH'(1); sub = 1'b1; end
            5'd18:       begin x = '0; y = iA; sub = 1'b1; end
            default:     ;
        endcase
        arith = sub ? ({1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin})
                    : ({1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin});
        ar  = arith[M:0];
        ovf = sub ? ((x[M] != y[M]) && (ar[M] != x[M]))
                  : ((x[M] == y[M]) && (ar[M] != x[M]));
        aux = x[4] ^ y[4] ^ ar[4];

        alu_res   = iA;
        alu_flags = iFlags;
        case (iFunc)
            5'd0, 5'd2, 5'd3, 5'd5, 5'd7, 5'd18: begin
                alu_res   = ar;
                alu_flags = mk_flags(ovf, ar, aux, arith[WIDTH]);
            end
            5'd16, 5'd17: begin
                alu_res   = ar;
                alu_flags = mk_flags(ovf, ar, aux, iFlags[0]);
            end
            5'd1: begin alu_res = iA | iB; alu_flags = mk_flags(1'b0, iA | iB, 1'b0, 1'b0); end
            5'd4: begin alu_res = iA & iB; alu_flags = mk_flags(1'b0, iA & iB, 1'b0, 1'b0); end
            5'd6: begin alu_res = iA ^ iB; alu_flags = mk_flags(1'b0, iA ^ iB, 1'b0, 1'b0); end
            5'd19: alu_res = ~iA;
            default: ;
        endcase
    end

    // One shift/rotate step; sh_op is iFunc[2:0] of opcodes 8-15.
    logic [WIDTH-1:0] sw;
    logic             sc, sof;
    logic [5:0]       shift_flags;

    always_comb begin
        case (sh_op)
            3'd0:    begin sw = {work[M-1:0], work[M]}; sc = work[M]; end
            3'd1:    begin sw = {work[0], work[M:1]};   sc = work[0]; end
            3'd2:    begin sw = {work[M-1:0], carry};   sc = work[M]; end
            3'd3:    begin sw = {carry, work[M:1]};     sc = work[0]; end
            3'd5:    begin sw = {1'b0, work[M:1]};      sc = work[0]; end
            3'd7:    begin sw = {work[M], work[M:1]};   sc = work[0]; end
            default: begin sw = {work[M-1:0], 1'b0};    sc = work[M]; end
        endcase
        case (sh_op)
            3'd1, 3'd3: sof = sw[M] ^ sw[M-1];
            3'd5:       sof = orig_msb;
            3'd7:       sof = 1'b0;
            default:    sof = sw[M] ^ sc;
        endcase
        // Shifts recompute ZF/SF/PF; rotates carry them over from the sampled flags.
        shift_flags = sh_op[2] ? mk_flags(sof, sw, 1'b0, sc) : {sof, sh_flags[4:1], sc};
    end

    always_comb begin
        state_n     = state;
        work_n      = work;
        carry_n     = carry;
        remaining_n = remaining;
        sh_op_n     = sh_op;
        sh_flags_n  = sh_flags;
        orig_msb_n  = orig_msb;
        done_n      = 1'b0;
        result_n    = oResult;
        flags_n     = oFlags;
        case (state)
            IDLE: if (iStart) begin
                if (iFunc[4:3] == 2'b01 && iCount != 5'd0) begin
                    state_n     = SHIFT;
                    work_n      = iA;
                    carry_n     = iFlags[0];
                    remaining_n = iCount;
                    sh_op_n     = iFunc[2:0];
                    sh_flags_n  = iFlags;
                    orig_msb_n  = iA[M];
                end else begin
                    done_n   = 1'b1;
                    result_n = (iFunc[4:3] == 2'b01) ? iA : alu_res;
                    flags_n  = (iFunc[4:3] == 2'b01) ? iFlags : alu_flags;
                end
            end
            SHIFT: begin
                work_n      = sw;
                carry_n     = sc;
                remaining_n = remaining - 5'd1;
                if (remaining == 5'd1) begin
                    state_n  = IDLE;
                    done_n   = 1'b1;
                    result_n = sw;
                    flags_n  = shift_flags;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            work      <= '0;
            carry     <= 1'b0;
            remaining <= '0;
            sh_op     <= '0;
            sh_flags  <= '0;
            orig_msb  <= 1'b0;
            oDone     <= 1'b0;
            oResult   <= '0;
            oFlags    <= '0;
        end else begin
            state     <= state_n;
            work      <= work_n;
            carry     <= carry_n;
            remaining <= remaining_n;
            sh_op     <= sh_op_n;
            sh_flags  <= sh_flags_n;
            orig_msb  <= orig_msb_n;
            oDone     <= done_n;
            oResult   <= result_n;
            oFlags    <= flags_n;
        end
    end

    assign oBusy = (state == SHIFT);
endmodule

// File: tb/tb_exec_alu_mc.sv
// Directed bench for exec_alu_mc: vector table on a 16-bit instance plus
// hand-written handshake, reset and 8-bit ring-rotation sequences.
module tb_exec_alu_mc;
    localparam logic [4:0] ADD = 0, OR_ = 1, ADC = 2, SBB = 3, AND_ = 4, SUB = 5, XOR_ = 6, CMP = 7;
    localparam logic [4:0] ROL = 8, ROR = 9, RCL = 10, RCR = 11, SHL = 12, SHR = 13, SAR = 15;
    localparam logic [4:0] INC = 16, DEC = 17, NEG = 18, NOT_ = 19;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, start8 = 1'b0;
    logic [4:0]  func = '0, count = '0;
    logic [15:0] a = '0, b = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [5:0]  fin = '0;
    logic        busy, done, busy8, done8;
    logic [15:0] res;
    logic [7:0]  res8;
    logic [5:0]  fl, fl8;

    int checks = 0, errors = 0;

    exec_alu_mc #(.WIDTH(16)) dut (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iFunc(func), .iA(a), .iB(b),
        .iCount(count), .iFlags(fin), .oBusy(busy), .oDone(done), .oResult(res), .oFlags(fl));

    exec_alu_mc #(.WIDTH(8)) dut8 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start8), .iFunc(func), .iA(a8), .iB(b8),
        .iCount(count), .iFlags(fin), .oBusy(busy8), .oDone(done8), .oResult(res8), .oFlags(fl8));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one op on the 16-bit instance and wait (bounded) for oDone.
    task automatic do_op(input logic [4:0] f, input logic [15:0] va, input logic [15:0] vb,
                         input logic [4:0] c, input logic [5:0] vf,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        func = f; a = va; b = vb; count = c; fin = vf; start = 1'b1;
        lat = 1; busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 64) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done timeout", 32'(lat), 32'(0));
        else       check("busy low at done", 32'(busy), 32'(0));
    endtask

    typedef struct {
        logic [4:0]  func;
        logic [15:0] a, b;
        logic [4:0]  cnt;
        logic [5:0]  fin;
        logic [15:0] res;
        logic [5:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[23];

    initial begin
        int lat, bc, dones;

        vecs[0]  = '{ADD,  16'h7FFF, 16'h0001, 5'd0,  6'b000000, 16'h8000, 6'b110110, 1};
        vecs[1]  = '{SUB,  16'h0000, 16'h0001, 5'd0,  6'b000000, 16'hFFFF, 6'b010111, 1};
        vecs[2]  = '{ADC,  16'hFFFF, 16'h0000, 5'd0,  6'b000001, 16'h0000, 6'b001111, 1};
        vecs[3]  = '{SBB,  16'h0005, 16'h0003, 5'd0,  6'b000001, 16'h0001, 6'b000000, 1};
        vecs[4]  = '{AND_, 16'hF0F0, 16'h0FF0, 5'd0,  6'b111111, 16'h00F0, 6'b000010, 1};
        vecs[5]  = '{OR_,  16'h8000, 16'h0001, 5'd0,  6'b000000, 16'h8001, 6'b010000, 1};
        vecs[6]  = '{XOR_, 16'h1234, 16'h1234, 5'd0,  6'b000000, 16'h0000, 6'b001010, 1};
        vecs[7]  = '{CMP,  16'h0003, 16'h0005, 5'd0,  6'b000000, 16'hFFFE, 6'b010101, 1};
        vecs[8]  = '{INC,  16'hFFFF, 16'h0000, 5'd0,  6'b000001, 16'h0000, 6'b001111, 1};
        vecs[9]  = '{DEC,  16'h8000, 16'h0000, 5'd0,  6'b000000, 16'h7FFF, 6'b100110, 1};
        vecs[10] = '{NEG,  16'h0001, 16'h0000, 5'd0,  6'b000000, 16'hFFFF, 6'b010111, 1};
        vecs[11] = '{NEG,  16'h0000, 16'h0000, 5'd0,  6'b000001, 16'h0000, 6'b001010, 1};
        vecs[12] = '{NOT_, 16'h00FF, 16'h0000, 5'd0,  6'b101010, 16'hFF00, 6'b101010, 1};
        vecs[13] = '{5'd25,16'hABCD, 16'h1111, 5'd0,  6'b010101, 16'hABCD, 6'b010101, 1};
        vecs[14] = '{SHL,  16'h4001, 16'h0000, 5'd1,  6'b000000, 16'h8002, 6'b110000, 2};
        vecs[15] = '{SAR,  16'h8000, 16'h0000, 5'd15, 6'b000000, 16'hFFFF, 6'b010010, 16};
        vecs[16] = '{SHL,  16'hFFFF, 16'h0000, 5'd17, 6'b000000, 16'h0000, 6'b001010, 18};
        vecs[17] = '{SHR,  16'h8001, 16'h0000, 5'd1,  6'b000000, 16'h4000, 6'b100011, 2};
        vecs[18] = '{ROL,  16'h8001, 16'h0000, 5'd1,  6'b011110, 16'h0003, 6'b111111, 2};
        vecs[19] = '{ROR,  16'h0001, 16'h0000, 5'd1,  6'b000000, 16'h8000, 6'b100001, 2};
        vecs[20] = '{RCR,  16'h0001, 16'h0000, 5'd1,  6'b000000, 16'h0000, 6'b000001, 2};
        vecs[21] = '{SHL,  16'h1234, 16'h0000, 5'd0,  6'b101011, 16'h1234, 6'b101011, 1};
        vecs[22] = '{RCL,  16'h0001, 16'h0000, 5'd2,  6'b000001, 16'h0006, 6'b000000, 3};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset done", 32'(done), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset result", 32'(res), 32'(0));
        check("reset flags", 32'(fl), 32'(0));

        for (int i = 0; i < 23; i++) begin
            do_op(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].cnt, vecs[i].fin, lat, bc);
            check($sformatf("v%0d result", i), 32'(res), 32'(vecs[i].res));
            check($sformatf("v%0d flags", i), 32'(fl), 32'(vecs[i].fl));
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d busy cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
            @(negedge clk);
            check($sformatf("v%0d done pulse", i), 32'(done), 32'(0));
            check($sformatf("v%0d result hold", i), 32'(res), 32'(vecs[i].res));
        end

        // Asynchronous reset between edges clears outputs at once.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst result", 32'(res), 32'(0));
        check("async rst flags", 32'(fl), 32'(0));
        check("async rst done", 32'(done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (4) begin @(negedge clk); if (done) dones++; end
        check("no done after release", 32'(dones), 32'(0));

        // 8-bit RCL by 9 rotates the whole 9-bit ring back to the start.
        @(negedge clk);
        func = RCL; a8 = 8'h81; count = 5'd9; fin = 6'b000000; start8 = 1'b1;
        lat = 1; bc = 0;
        @(negedge clk);
        start8 = 1'b0;
        while (!done8 && lat < 64) begin
            if (busy8) bc++;
            @(negedge clk);
            lat++;
        end
        check("rcl8 latency", 32'(lat), 32'(10));
        check("rcl8 busy cycles", 32'(bc), 32'(9));
        check("rcl8 result", 32'(res8), 32'(8'h81));
        check("rcl8 flags", 32'(fl8), 32'(6'b100000));

        // iStart during a ROR is ignored; iStart in its oDone cycle is taken.
        @(negedge clk);
        func = ROR; a = 16'h000F; count = 5'd4; fin = 6'b000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        @(negedge clk);
        lat = 2;
        func = ADD; a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        lat = 3;
        start = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("ror latency", 32'(lat), 32'(5));
        check("ror result", 32'(res), 32'(16'hF000));
        check("ror flags", 32'(fl), 32'(6'b000001));
        func = INC; a = 16'hFFFF; fin = 6'b000001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("inc on done done", 32'(done), 32'(1));
        check("inc on done result", 32'(res), 32'(16'h0000));
        check("inc on done flags", 32'(fl), 32'(6'b001111));
        @(negedge clk);
        check("inc single done", 32'(done), 32'(0));

        // Reset in the third busy cycle of an 8-count SHR aborts it.
        @(negedge clk);
        func = SHR; a = 16'hFFFF; count = 5'd8; fin = 6'b000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("shr busy before rst", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("shr rst busy", 32'(busy), 32'(0));
        check("shr rst flags", 32'(fl), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin @(negedge clk); if (done) dones++; end
        check("shr aborted no done", 32'(dones), 32'(0));
        do_op(ADD, 16'h0001, 16'h0001, 5'd0, 6'b000000, lat, bc);
        check("post rst latency", 32'(lat), 32'(1));
        check("post rst result", 32'(res), 32'(16'h0002));
        check("post rst flags", 32'(fl), 32'(6'b000000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_alu_mc.md
# exec_alu_mc

Multi-cycle, width-parametrised successor to the single-cycle execution ALU, sitting in the CPU execute stage between the register-read mux and the writeback/flags register. It adds registered results, a start/done handshake, full x86 arithmetic flags (OF, SF, ZF, AF, PF, CF), and bit-serial shift/rotate operations with a masked count, executed one bit per clock.

## Interface
- WIDTH, 16, operand/result width; legal values 8, 16, 32
- iClk  in  1  clock, all state updates on rising edge
- iRst_n  in  1  asynchronous active-low reset
- iStart  in  1  start pulse; sampled only when FSM is IDLE
- iFunc  in  5  operation code (see Operation)
- iA  in  WIDTH  operand A / shift source
- iB  in  WIDTH  operand B
- iCount  in  5  shift/rotate count, used as-is (5-bit mask is implicit)
- iFlags  in  6  current flags {OF,SF,ZF,AF,PF,CF}; source of preserved flags and carry-in
- oBusy  out  1  high while a shift/rotate is iterating
- oDone  out  1  one-cycle pulse: oResult/oFlags valid
- oResult  out  WIDTH  registered result; holds until next oDone
- oFlags  out  6  registered flags {OF,SF,ZF,AF,PF,CF}; holds until next oDone

## Operation
- Opcodes 0-7 (single-cycle, x86 group-1 order): ADD, OR, ADC, SBB, AND, SUB, XOR, CMP. ADC/SBB take carry from iFlags[0]. CMP computes A-B exactly as SUB (caller suppresses writeback).
- Opcodes 8-15 (multi-cycle): ROL, ROR, RCL, RCR, SHL, SHR, SAL (= SHL), SAR.
- Opcodes 16-19 (single-cycle): INC, DEC, NEG, NOT. Opcodes 20-31: result = iA, flags = iFlags.
- Arithmetic flags: CF = carry out (borrow for SUB/SBB/CMP/NEG); OF = signed overflow; AF = carry/borrow out of bit 3; ZF = result==0; SF = result[WIDTH-1]; PF = even parity of result[7:0].
- Logic ops: CF=OF=AF=0; ZF/SF/PF from result.
- INC/DEC: CF preserved from iFlags, others computed. NEG: CF = (iA != 0). NOT: all flags preserved.
- Shifts/rotates: FSM IDLE -> SHIFT with working register = iA, carry = iFlags[0], remaining = iCount. Each SHIFT cycle moves one bit; CF = last bit shifted out; RCL/RCR rotate through a WIDTH+1 ring including CF. Counts above WIDTH keep iterating bitwise (e.g. SHL 8-bit by 9 -> result 0, CF 0).
- Shift OF: SHL/ROL/RCL = result MSB xor CF; SHR = original iA MSB; SAR = 0; ROR/RCR = result[MSB] xor result[MSB-1]. Shifts update ZF/SF/PF from result, AF = 0; rotates preserve ZF/SF/PF/AF.
- iCount == 0: no iteration; result = iA, flags = iFlags.
- FSM states: IDLE, SHIFT. SHIFT -> IDLE when the last bit is moved.

## Timing
- Reset: state IDLE, oBusy 0, oDone 0, oResult 0, oFlags 0. Reset mid-shift aborts immediately; no oDone is issued.
- Single-cycle ops and zero-count shifts: iStart at cycle N -> oDone at N+1, oBusy stays 0.
- Shift with count c>0: iStart at N -> oBusy high N+1..N+c, oDone at N+c+1, oBusy low at N+c+1.
- iStart while oBusy is ignored (no queueing). iStart in the oDone cycle is accepted (FSM already IDLE); back-to-back single-cycle ops give oDone every cycle.
- Inputs iA, iB, iFunc, iCount, iFlags are sampled only at the accepted iStart; later changes do not affect the operation in flight.
- oResult/oFlags change only in the cycle oDone is high.

## Test plan
- Reset: drive iRst_n low asynchronously mid-cycle -> all outputs 0 immediately; release, no spurious oDone.
- WIDTH=16 ADD 0x7FFF+0x0001 -> oDone at N+1, result 0x8000, OF=1 SF=1 ZF=0 AF=1 PF=1 CF=0; SUB 0x0000-0x0001 -> 0xFFFF, CF=1 AF=1 OF=0.
- WIDTH=8 RCL 0x81, iCount=9, CF_in=0 -> oBusy 9 cycles, oDone at N+10, result 0x81, CF=0 (full ring rotation).
- WIDTH=16 SHL 0x4001, iCount=1 -> oDone N+2, result 0x8002, CF=0, OF=1; SAR 0x8000 count 15 -> 0xFFFF, CF=0, oDone N+16.
- iStart pulsed during oBusy of a 4-count ROR -> ignored, exactly one oDone; iStart on that oDone cycle with INC 0xFFFF, CF_in=1 -> next cycle result 0x0000, ZF=1, CF=1 (preserved).
- Assert iRst_n low at cycle 3 of an 8-count SHR -> no oDone, outputs 0, next iStart after release behaves normally.
